// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-FU 2-deep result buffers feeding a 4-slot registered CDB,
// granted round-robin starting at rr_ptr each cycle.
module cdb_arbiter #(
  parameter int unsigned NUM_FU = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_FU-1:0]    fu_valid,
  input  logic [4*NUM_FU-1:0]  fu_index_flat,
  input  logic [16*NUM_FU-1:0] fu_value_flat,
  output logic [NUM_FU-1:0]    fu_ready,
  output logic [3:0]           cdb_valid_flat,
  output logic [15:0]          cdb_indices_flat,
  output logic [63:0]          cdb_values_flat,
  output logic [2:0]           grant_count,
  output logic                 busy
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned VAL_W = 16;
  localparam int unsigned SLOTS = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned GNT_W = 3;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [VAL_W-1:0] value;
  } entry_t;

  logic [CNT_W-1:0] count_q [NUM_FU];
  logic [CNT_W-1:0] count_d [NUM_FU];
  entry_t           head_q  [NUM_FU];
  entry_t           head_d  [NUM_FU];
  entry_t           tail_q  [NUM_FU];
  entry_t           tail_d  [NUM_FU];
  entry_t           in_c    [NUM_FU];
  logic [NUM_FU-1:0] push_c;
  logic [NUM_FU-1:0] grant_c;
  logic [NUM_FU-1:0] nonempty_c;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SUM_W-1:0] scan_sum_c;
  logic [PTR_W-1:0] scan_idx_c;
  logic [PTR_W-1:0] last_grant_c;
  logic [GNT_W-1:0] n_grant_c;

  logic [SLOTS-1:0] cdb_valid_q, cdb_valid_d;
  entry_t           slot_q [SLOTS];
  entry_t           slot_d [SLOTS];
  logic [GNT_W-1:0] grant_count_q, grant_count_d;

  // Round-robin scan: first up to four non-empty FUs from rr_ptr fill slots 0..3 in order.
  always_comb begin
    grant_c      = '0;
    n_grant_c    = '0;
    last_grant_c = rr_ptr_q;
    scan_sum_c   = '0;
    scan_idx_c   = '0;
    cdb_valid_d  = '0;
    for (int s = 0; s < SLOTS; s++) begin
      slot_d[s] = '0;
    end
    for (int j = 0; j < NUM_FU; j++) begin
      scan_sum_c = {1'b0, rr_ptr_q} + SUM_W'(j);
      if (scan_sum_c >= SUM_W'(NUM_FU)) begin
        scan_sum_c = scan_sum_c - SUM_W'(NUM_FU);
      end
      scan_idx_c = scan_sum_c[PTR_W-1:0];
      if ((count_q[scan_idx_c] != '0) && (n_grant_c < GNT_W'(SLOTS))) begin
        grant_c[scan_idx_c]          = 1'b1;
        slot_d[n_grant_c[1:0]]       = head_q[scan_idx_c];
        cdb_valid_d[n_grant_c[1:0]]  = 1'b1;
        last_grant_c                 = scan_idx_c;
        n_grant_c                    = n_grant_c + GNT_W'(1);
      end
    end
    grant_count_d = n_grant_c;
    rr_ptr_d      = rr_ptr_q;
    if (n_grant_c != '0) begin
      rr_ptr_d = (last_grant_c == PTR_W'(NUM_FU - 1)) ? '0 : last_grant_c + PTR_W'(1);
    end
  end

  // Holding buffers: head is the oldest entry; a grant pops head, a push lands behind it.
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      fu_ready[k]   = (count_q[k] < CNT_W'(2)) && rst_n;
      push_c[k]     = fu_valid[k] && fu_ready[k];
      in_c[k].index = fu_index_flat[IDX_W*k +: IDX_W];
      in_c[k].value = fu_value_flat[VAL_W*k +: VAL_W];
      nonempty_c[k] = (count_q[k] != '0);
      count_d[k]    = count_q[k];
      head_d[k]     = head_q[k];
      tail_d[k]     = tail_q[k];
      case ({push_c[k], grant_c[k]})
        2'b10: begin
          if (count_q[k] == '0) begin
            head_d[k] = in_c[k];
          end else begin
            tail_d[k] = in_c[k];
          end
          count_d[k] = count_q[k] + CNT_W'(1);
        end
        2'b01: begin
          head_d[k]  = tail_q[k];
          count_d[k] = count_q[k] - CNT_W'(1);
        end
        2'b11: begin
          if (count_q[k] == CNT_W'(1)) begin
            head_d[k] = in_c[k];
          end else begin
            head_d[k] = tail_q[k];
            tail_d[k] = in_c[k];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_FU; k++) begin
        count_q[k] <= '0;
        head_q[k]  <= '0;
        tail_q[k]  <= '0;
      end
      rr_ptr_q      <= '0;
      cdb_valid_q   <= '0;
      grant_count_q <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        slot_q[s] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        count_q[k] <= count_d[k];
        head_q[k]  <= head_d[k];
        tail_q[k]  <= tail_d[k];
      end
      rr_ptr_q      <= rr_ptr_d;
      cdb_valid_q   <= cdb_valid_d;
      grant_count_q <= grant_count_d;
      for (int s = 0; s < SLOTS; s++) begin
        slot_q[s] <= slot_d[s];
      end
    end
  end

  // Slot i maps to the most-significant end of each flat bus.
  always_comb begin
    cdb_valid_flat   = '0;
    cdb_indices_flat = '0;
    cdb_values_flat  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      cdb_valid_flat[SLOTS-1-i]                        = cdb_valid_q[i];
      cdb_indices_flat[IDX_W*(SLOTS-1-i) +: IDX_W]     = slot_q[i].index;
      cdb_values_flat[VAL_W*(SLOTS-1-i) +: VAL_W]      = slot_q[i].value;
    end
    grant_count = grant_count_q;
    busy        = rst_n && (|nonempty_c);
  end

endmodule
